// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad, debounces press and release, and hands the
// pressed key's 4-bit code to a downstream consumer over valid/ready.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   row[3:0]   keypad rows (1 = key in the driven column closed), async to clk
//   col[3:0]   one-hot active-high column drive
//   key_code   code of the accepted key
//   key_valid  key_code holds an unconsumed key
//   key_ready  consumer takes key_code at a posedge where key_valid=1
//   key_held   a debounced key is currently down
//   overflow   sticky: a key was dropped because key_valid was still pending
//
// Key map (row r, col c0..c3):
//   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: * 0 # D
//   digits -> value, A..D -> 0xA..0xD, * -> 0xE, # -> 0xF
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV     = 16,   // cycles per column, >= 4
  parameter int DEBOUNCE_CNT = 1000  // stable cycles to accept press/release, >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [3:0]       row_meta, row_s;
  logic [3:0]       col_next;
  logic [DIV_W-1:0] div_cnt, div_cnt_next;
  logic [DEB_W-1:0] deb_cnt, deb_cnt_next;
  logic [1:0]       lat_row, lat_row_next;
  logic [1:0]       lat_col, lat_col_next;
  logic [3:0]       key_code_next;
  logic             key_valid_next;
  logic             key_held_next;
  logic             overflow_next;

  logic             publish;
  logic             single_row;
  logic [3:0]       lat_mask;
  logic [3:0]       col_rot;

  // Index of a one-hot nibble; only used when exactly one bit is set.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    case (v)
      4'b0010: onehot_idx = 2'd1;
      4'b0100: onehot_idx = 2'd2;
      4'b1000: onehot_idx = 2'd3;
      default: onehot_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_lookup = 4'h1;
      4'b00_01: key_lookup = 4'h2;
      4'b00_10: key_lookup = 4'h3;
      4'b00_11: key_lookup = 4'hA;
      4'b01_00: key_lookup = 4'h4;
      4'b01_01: key_lookup = 4'h5;
      4'b01_10: key_lookup = 4'h6;
      4'b01_11: key_lookup = 4'hB;
      4'b10_00: key_lookup = 4'h7;
      4'b10_01: key_lookup = 4'h8;
      4'b10_10: key_lookup = 4'h9;
      4'b10_11: key_lookup = 4'hC;
      4'b11_00: key_lookup = 4'hE;  // *
      4'b11_01: key_lookup = 4'h0;
      4'b11_10: key_lookup = 4'hF;  // #
      default:  key_lookup = 4'hD;
    endcase
  endfunction

  assign single_row = (row_s == 4'b0001) || (row_s == 4'b0010) ||
                      (row_s == 4'b0100) || (row_s == 4'b1000);
  assign lat_mask   = 4'b0001 << lat_row;
  assign col_rot    = {col[2:0], col[3]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      row_meta  <= 4'b0000;
      row_s     <= 4'b0000;
      col       <= 4'b0001;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      row_meta  <= row;
      row_s     <= row_meta;
      col       <= col_next;
      div_cnt   <= div_cnt_next;
      deb_cnt   <= deb_cnt_next;
      lat_row   <= lat_row_next;
      lat_col   <= lat_col_next;
      key_code  <= key_code_next;
      key_valid <= key_valid_next;
      key_held  <= key_held_next;
      overflow  <= overflow_next;
    end
  end

  always_comb begin
    state_next     = state;
    col_next       = col;
    div_cnt_next   = div_cnt;
    deb_cnt_next   = deb_cnt;
    lat_row_next   = lat_row;
    lat_col_next   = lat_col;
    key_held_next  = key_held;
    key_code_next  = key_code;
    key_valid_next = key_valid;
    overflow_next  = overflow;
    publish        = 1'b0;

    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_next = '0;
          if (single_row) begin
            // Freeze the column and start confirming this key.
            lat_row_next = onehot_idx(row_s);
            lat_col_next = onehot_idx(col);
            deb_cnt_next = '0;
            state_next   = DEBOUNCE;
          end else begin
            col_next = col_rot;
          end
        end else begin
          div_cnt_next = div_cnt + DIV_W'(1);
        end
      end

      DEBOUNCE: begin
        if (row_s == lat_mask) begin
          if (deb_cnt == DEB_LAST) begin
            publish       = 1'b1;
            key_held_next = 1'b1;
            deb_cnt_next  = '0;
            state_next    = HELD;
          end else begin
            deb_cnt_next = deb_cnt + DEB_W'(1);
          end
        end else begin
          col_next     = col_rot;
          div_cnt_next = '0;
          deb_cnt_next = '0;
          state_next   = SCAN;
        end
      end

      HELD: begin
        // Anything but all-rows-open keeps us here; no second key is produced.
        if (row_s == 4'b0000) begin
          deb_cnt_next = '0;
          state_next   = RELEASE;
        end
      end

      default: begin  // RELEASE
        if (row_s == 4'b0000) begin
          if (deb_cnt == DEB_LAST) begin
            key_held_next = 1'b0;
            col_next      = col_rot;
            div_cnt_next  = '0;
            deb_cnt_next  = '0;
            state_next    = SCAN;
          end else begin
            deb_cnt_next = deb_cnt + DEB_W'(1);
          end
        end else begin
          deb_cnt_next = '0;
          state_next   = HELD;
        end
      end
    endcase

    // Consumer handshake, then a new key may overwrite it on the same edge.
    if (key_valid && key_ready) begin
      key_valid_next = 1'b0;
    end
    if (publish) begin
      if (!key_valid || key_ready) begin
        key_code_next  = key_lookup(lat_row, lat_col);
        key_valid_next = 1'b1;
      end else begin
        overflow_next = 1'b1;
      end
    end
  end

endmodule
